// File: rtl/fifo_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_burst_ctrl
// Description : Read-side sequencer of an asynchronous FIFO (rclk domain).
//               Computes FIFO occupancy from the synchronized Gray write
//               pointer and the local Gray read pointer. Drains the FIFO in
//               fixed-length bursts onto a registered valid/ready stream with
//               a last-word marker. Also provides a discard-all flush.
// Ports       : rclk, rrst_n      - read clock, async active-low reset
//               sync_wptr, rptr   - Gray write (synchronized) / read pointers
//               rempty, rdata     - FIFO empty flag, combinational read data
//               rinc              - pop request to read pointer logic
//               burst_len         - words per burst (0 = off, clamped to depth)
//               flush             - single-cycle discard-all request
//               m_valid/m_data/m_last/m_ready - output stream
//               level             - current occupancy 0..2^ADDR_RANGE
//               busy              - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_burst_ctrl #(
  parameter int ADDR_RANGE = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_RANGE:0]   sync_wptr,
  input  logic [ADDR_RANGE:0]   rptr,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic [ADDR_RANGE:0]   burst_len,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_RANGE:0]   level,
  output logic                  busy
);

  localparam int PW = ADDR_RANGE + 1;
  localparam logic [PW-1:0] c_depth = {1'b1, {ADDR_RANGE{1'b0}}};
  localparam logic [PW-1:0] c_one   = {{ADDR_RANGE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           remaining_q, remaining_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic [PW-1:0]           burst_len_eff;
  logic                    accept;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Modulo subtraction of the binary pointers absorbs pointer wrap-around.
  assign level         = gray2bin(sync_wptr) - gray2bin(rptr);
  assign burst_len_eff = (burst_len > c_depth) ? c_depth : burst_len;
  assign accept        = m_valid_q && m_ready;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    flush_pend_d = flush_pend_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    rinc         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Flush (new or deferred from a burst) wins over starting a burst.
        if (flush || flush_pend_q) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b0;
        end else if ((burst_len_eff != '0) && (level >= burst_len_eff)) begin
          state_d     = ST_BURST;
          remaining_d = burst_len_eff;
        end
      end

      ST_BURST: begin
        // A flush never truncates a burst; it is replayed once back in IDLE.
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        // Pop only when the output register is free or being emptied now.
        rinc = !rempty && (remaining_q != '0) && (!m_valid_q || m_ready);
        if (rinc) begin
          m_data_d    = rdata;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == c_one);
          remaining_d = remaining_q - c_one;
        end else if (accept) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
        if (accept && m_last_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        // Popped words are discarded; the output register is untouched.
        rinc = !rempty;
        if (rempty) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      flush_pend_q <= flush_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_burst_ctrl
// Description : Self-checking bench for fifo_rd_burst_ctrl. A small FIFO
//               environment supplies pointers, empty flag and read data; a
//               transaction-level model predicts the outputs every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_burst_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [3:0] sync_wptr, rptr, burst_len, level;
  logic       rempty, rinc, flush, m_valid, m_last, m_ready, busy;
  logic [7:0] rdata, m_data;

  // FIFO environment: binary pointers, wbin owned by stimulus, rbin by pops.
  logic [3:0] wbin    = 4'd0;
  logic [3:0] rbin    = 4'd0;
  int         pop_cnt = 0;
  logic [7:0] mem [0:7];

  int checks = 0;
  int fails  = 0;

  logic [7:0] log_d[$];
  bit         log_l[$];

  always #5 rclk = ~rclk;

  assign sync_wptr = wbin ^ (wbin >> 1);
  assign rptr      = rbin ^ (rbin >> 1);
  assign rempty    = (wbin == rbin);
  assign rdata     = mem[rbin[2:0]];

  always @(posedge rclk) begin
    if (rinc) begin
      rbin    <= rbin + 4'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  fifo_rd_burst_ctrl #(.ADDR_RANGE(3), .DATA_WIDTH(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .sync_wptr (sync_wptr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .burst_len (burst_len),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .level     (level),
    .busy      (busy)
  );

  function automatic int fill();
    logic [3:0] d;
    d = wbin - rbin;
    return int'(d);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    fails++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    mem[wbin[2:0]] = d;
    wbin = wbin + 4'd1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    tick();
    tick();
    while ((busy || m_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) timeout(nm);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk_log(input string nm, input logic [7:0] base, input int n);
    chk({nm, "_count"}, log_d.size(), n);
    for (int i = 0; i < n && i < log_d.size(); i++) begin
      chk({nm, "_data"}, log_d[i], base + 8'(i));
      chk({nm, "_last"}, log_l[i], (i == n - 1));
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: tracks the burst as counts of words popped/delivered and
  // an output slot queue; predicts every output once per cycle.
  // --------------------------------------------------------------------------
  initial begin : compare
    int         mode;   // 0 idle, 1 bursting, 2 flushing
    int         bsize, npop, ndel, eff, lvl;
    bit         pend, emp, exp_rinc, acc;
    logic [7:0] sq[$];
    bit         sl[$];
    mode = 0; bsize = 0; npop = 0; ndel = 0; pend = 0;
    forever begin
      @(negedge rclk);
      lvl = fill();
      emp = (lvl == 0);
      if (rrst_n !== 1'b1) begin
        chk("rst_rinc", rinc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_level", level, lvl);
        mode = 0; pend = 0; bsize = 0; npop = 0; ndel = 0;
        sq.delete();
        sl.delete();
      end else begin
        exp_rinc = 1'b0;
        if (mode == 1)
          exp_rinc = !emp && (npop < bsize) && (sq.size() == 0 || m_ready);
        else if (mode == 2)
          exp_rinc = !emp;
        chk("level", level, lvl);
        chk("rinc", rinc, exp_rinc);
        chk("busy", busy, (mode != 0));
        chk("m_valid", m_valid, (sq.size() != 0));
        chk("m_last", m_last, (sq.size() != 0) ? sl[0] : 1'b0);
        if (sq.size() != 0) chk("m_data", m_data, sq[0]);
        if (m_valid && m_ready) begin
          log_d.push_back(m_data);
          log_l.push_back(m_last);
        end
        eff = (burst_len > 4'd8) ? 8 : int'(burst_len);
        acc = (sq.size() != 0) && m_ready;
        case (mode)
          0: begin
            if (flush || pend) begin
              mode = 2;
              pend = 0;
            end else if (eff != 0 && lvl >= eff) begin
              mode = 1; bsize = eff; npop = 0; ndel = 0;
            end
          end
          1: begin
            if (flush) pend = 1;
            if (acc) begin
              void'(sq.pop_front());
              void'(sl.pop_front());
              ndel++;
            end
            if (exp_rinc) begin
              npop++;
              sq.push_back(mem[rbin[2:0]]);
              sl.push_back(npop == bsize);
            end
            if (ndel == bsize) mode = 0;
          end
          default: begin
            if (emp) mode = 0;
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim
    int n, p0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rrst_n = 1'b0; burst_len = 4'd0; flush = 1'b0; m_ready = 1'b1;
    tick(); tick(); tick();
    chk("reset_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rinc", rinc, 0);
    chk("reset_data", m_data, 0);
    rrst_n = 1'b1;
    tick();

    // Single burst: 5 words, burst of 4, one left behind.
    for (int i = 0; i < 5; i++) begin wr(8'hA0 + 8'(i)); tick(); end
    log_d.delete(); log_l.delete();
    burst_len = 4'd4;
    wait_idle("single_wait");
    chk_log("single", 8'hA0, 4);
    chk("single_level", level, 1);
    pulse_flush();
    wait_idle("drain1_wait");
    chk("drain1_level", level, 0);

    // Threshold: levels 0..3 never start; the 4th word yields data 2 edges on.
    for (int k = 0; k < 3; k++) begin
      wr(8'hB0 + 8'(k));
      tick(); chk("thr_rinc", rinc, 0); chk("thr_busy", busy, 0);
      tick(); chk("thr_rinc", rinc, 0); chk("thr_busy", busy, 0);
    end
    log_d.delete(); log_l.delete();
    wr(8'hB3);
    tick();
    chk("thr_busy1", busy, 1);
    chk("thr_valid1", m_valid, 0);
    tick();
    chk("thr_valid2", m_valid, 1);
    chk("thr_data2", m_data, 8'hB0);
    wait_idle("thr_wait");
    chk_log("thr", 8'hB0, 4);

    // Backpressure: 8-word burst, ready toggling, burst_len changed mid-burst.
    burst_len = 4'd8;
    log_d.delete(); log_l.delete();
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin wr(8'hC0 + 8'(i)); m_ready = ~m_ready; tick(); end
    n = 0;
    while ((busy || m_valid) && n < 100) begin
      if (busy) burst_len = 4'd2;
      m_ready = ~m_ready;
      tick();
      n++;
    end
    if (n >= 100) timeout("bp_wait");
    m_ready = 1'b1;
    burst_len = 4'd0;
    chk_log("bp", 8'hC0, 8);
    chk("bp_pops", pop_cnt - p0, 8);

    // Wrap and full: align pointers to 12 so the fill crosses the wrap.
    for (int g = 0; g < 4 && wbin != 4'd12; g++) begin
      while (wbin != 4'd12 && fill() < 8) begin wr(8'h55); tick(); end
      pulse_flush();
      wait_idle("pad_wait");
    end
    chk("wrap_empty", level, 0);
    for (int i = 0; i < 8; i++) begin wr(8'hD0 + 8'(i)); tick(); end
    chk("wrap_level8", level, 8);
    log_d.delete(); log_l.delete();
    burst_len = 4'd15;
    wait_idle("wrap_wait");
    chk_log("wrap", 8'hD0, 8);
    chk("wrap_level0", level, 0);
    burst_len = 4'd0;

    // Flush during burst: 6 words, 4-word burst finishes, flush drops 2.
    for (int i = 0; i < 6; i++) begin wr(8'hE0 + 8'(i)); tick(); end
    log_d.delete(); log_l.delete();
    p0 = pop_cnt;
    burst_len = 4'd4;
    n = 0;
    while (!(m_valid && m_data == 8'hE1) && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("fl_find");
    pulse_flush();
    n = 0;
    while ((busy || fill() != 0) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("fl_wait");
    chk_log("fl", 8'hE0, 4);
    chk("fl_pops", pop_cnt - p0, 6);
    chk("fl_level", level, 0);
    burst_len = 4'd0;
    tick();

    // Async reset during the 3rd pop.
    for (int i = 0; i < 6; i++) begin wr(8'hF0 + 8'(i)); tick(); end
    p0 = pop_cnt;
    burst_len = 4'd4;
    n = 0;
    while ((pop_cnt - p0) < 2 && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("ar_find");
    chk("ar_rinc_before", rinc, 1);
    #1 rrst_n = 1'b0;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_last", m_last, 0);
    chk("ar_rinc", rinc, 0);
    chk("ar_busy", busy, 0);
    tick();
    #1 rrst_n = 1'b1;
    log_d.delete(); log_l.delete();
    wait_idle("ar_wait");
    chk_log("ar", 8'hF2, 4);
    chk("ar_pops", pop_cnt - p0, 6);
    burst_len = 4'd0;
    pulse_flush();
    wait_idle("drain2_wait");

    // Randomized traffic; the model checks every cycle.
    burst_len = 4'($urandom_range(1, 8));
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 1) == 1 && fill() < 8) wr(8'($urandom));
      m_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) burst_len = 4'($urandom_range(0, 15));
      tick();
    end
    flush = 1'b0;
    m_ready = 1'b1;
    burst_len = 4'd0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
